// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a word-addressed data memory.
// Handles byte/half/word access with extension, does read-modify-write for sub-word stores, and rejects bad requests.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_next;
    logic [1:0] offset, size;
    logic write, zext, accept, bad;
    logic [4:0] shift;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, mask, merged;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;

    always_comb begin
        req_ready = state == IDLE;
        resp_valid = state == RESP;
        mem_write_enable = state == WRITE;
        accept = req_valid && req_ready;
        bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00) || {2'b00, req_addr[31:2]} >= MEM_WORDS;
        state_next = state;
        if (accept) state_next = bad ? RESP : (req_write && req_size == 2'b10) ? WRITE : READ;
        else if (state == READ) state_next = write ? WRITE : RESP;
        else if (state == WRITE) state_next = RESP;
        else if (state == RESP) state_next = IDLE;
    end

    // mem_write_data still holds the right-aligned store data while in READ, so it feeds the merge
    always_comb begin
        shift = {offset, 3'b000};
        lane_b = 8'(mem_read_data >> shift);
        lane_h = offset[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_val = size == 2'b00 ? {{24{~zext & lane_b[7]}}, lane_b} :
                   size == 2'b01 ? {{16{~zext & lane_h[15]}}, lane_h} : mem_read_data;
        mask = (size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << shift;
        merged = (mem_read_data & ~mask) | ((mem_write_data << shift) & mask);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            offset <= '0;
            size <= '0;
            write <= 1'b0;
            zext <= 1'b0;
            mem_addr <= '0;
            mem_write_data <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            if (accept) begin
                offset <= req_addr[1:0];
                size <= req_size;
                write <= req_write;
                zext <= req_unsigned;
                if (bad) begin
                    resp_error <= 1'b1;
                    resp_rdata <= '0;
                end else begin
                    mem_addr <= {req_addr[31:2], 2'b00};
                    if (req_write) mem_write_data <= req_wdata;
                end
            end
            if (state == READ) begin
                if (write) mem_write_data <= merged;
                else begin
                    resp_rdata <= load_val;
                    resp_error <= 1'b0;
                end
            end
            if (state == WRITE) begin
                resp_rdata <= '0;
                resp_error <= 1'b0;
            end
        end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed requests checked against a byte-level memory model every cycle.
module tb_load_store_unit;
    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] lit;
        logic        lit_err;
    } req_t;
    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        er;
        int          nw;
    } exp_t;

    logic clk = 0, reset = 1, req_valid = 0, req_write = 0, req_unsigned = 0;
    logic [1:0] req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic req_ready, resp_valid, resp_error, mem_write_enable;
    logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
    logic [31:0] mem [0:4095] = '{default: 32'h0};
    logic [7:0] bytes [int];
    req_t reqq[$];
    exp_t pend[$];
    exp_t e_acc;
    int cyc = 0, wcount = 0, passed = 0, total = 0;

    load_store_unit #(.MEM_WORDS(4096)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;
    assign mem_read_data = mem[mem_addr[13:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_addr[13:2]] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at cycle %0d", name, act, req, cyc);
    endtask

    function automatic logic [7:0] getb(input int a);
        return bytes.exists(a) ? bytes[a] : 8'h00;
    endfunction

    function automatic logic [31:0] word_of(input int a);
        return {getb(a + 3), getb(a + 2), getb(a + 1), getb(a)};
    endfunction

    // Request-level model: a byte-addressed memory; latency only depends on request kind
    function automatic exp_t model(input req_t r);
        exp_t e;
        int nb;
        logic [31:0] v;
        nb = 1 << r.size;
        e.nw = 0;
        e.rd = 0;
        e.er = r.size == 2'd3 || r.addr % nb != 0 || r.addr / 4 >= 4096;
        if (e.er) e.due = 1;
        else if (r.write) begin
            for (int i = 0; i < nb; i++) bytes[int'(r.addr) + i] = r.wdata[8*i +: 8];
            e.nw = 1;
            e.due = nb == 4 ? 2 : 3;
        end else begin
            v = 0;
            for (int i = nb - 1; i >= 0; i--) v = (v << 8) | 32'(getb(int'(r.addr) + i));
            if (!r.uns && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
            e.rd = v;
            e.due = 2;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (mem_write_enable) wcount++;
        chk("req_ready", 32'(req_ready), 32'(pend.size() == 0));
        if (pend.size() == 0) chk("resp_valid_idle", 32'(resp_valid), 32'd0);
        else begin
            chk("resp_valid_timing", 32'(resp_valid), 32'(cyc == pend[0].due));
            if (resp_valid || cyc >= pend[0].due) begin
                if (resp_valid) begin
                    chk("resp_rdata", resp_rdata, pend[0].rd);
                    chk("resp_error", 32'(resp_error), 32'(pend[0].er));
                    chk("write_cycles", 32'(wcount), 32'(pend[0].nw));
                end
                void'(pend.pop_front());
                wcount = 0;
            end
        end
        if (reqq.size() != 0) begin
            req_valid = 1;
            req_write = reqq[0].write;
            req_size = reqq[0].size;
            req_unsigned = reqq[0].uns;
            req_addr = reqq[0].addr;
            req_wdata = reqq[0].wdata;
        end else req_valid = 0;
        #1;
        if (req_valid && req_ready) begin
            e_acc = model(reqq[0]);
            chk("model_rdata_pin", e_acc.rd, reqq[0].lit);
            chk("model_error_pin", 32'(e_acc.er), 32'(reqq[0].lit_err));
            e_acc.due += cyc;
            pend.push_back(e_acc);
            void'(reqq.pop_front());
        end
    end

    task automatic q(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] lit, input logic le);
        reqq.push_back('{w, s, u, a, d, lit, le});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((reqq.size() != 0 || pend.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(reqq.size() + pend.size()), 32'd0);
        reqq.delete();
        pend.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] saved;
        int n;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 0;

        q(1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        q(0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        q(1, 0, 0, 32'h12, 32'h0000005A, 32'h0, 0);
        q(0, 2, 0, 32'h10, 32'h0, 32'hDE5ABEEF, 0);
        q(0, 0, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
        q(0, 0, 1, 32'h13, 32'h0, 32'h000000DE, 0);
        q(0, 1, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
        q(0, 1, 1, 32'h10, 32'h0, 32'h0000BEEF, 0);
        wait_idle();
        chk("mem_word_0x10", mem[4], 32'hDE5ABEEF);

        q(1, 1, 0, 32'h11, 32'h0000FFFF, 32'h0, 1);
        q(0, 2, 0, 32'h12, 32'h0, 32'h0, 1);
        q(0, 3, 0, 32'h14, 32'h0, 32'h0, 1);
        q(0, 2, 0, 32'h4000, 32'h0, 32'h0, 1);
        q(1, 2, 0, 32'h4000, 32'h1, 32'h0, 1);
        q(1, 0, 0, 32'h4003, 32'h1, 32'h0, 1);
        q(0, 2, 0, 32'h3FFC, 32'h0, 32'h0, 0);
        wait_idle();
        chk("mem_0x10_after_errors", mem[4], 32'hDE5ABEEF);

        q(1, 1, 0, 32'h16, 32'hFFFF1234, 32'h0, 0);
        q(0, 1, 1, 32'h16, 32'h0, 32'h00001234, 0);
        q(1, 0, 0, 32'h18, 32'h00000080, 32'h0, 0);
        q(0, 0, 0, 32'h18, 32'h0, 32'hFFFFFF80, 0);
        q(1, 2, 0, 32'h1C, 32'hA5A50F0F, 32'h0, 0);
        q(0, 2, 0, 32'h1C, 32'h0, 32'hA5A50F0F, 0);
        q(1, 0, 0, 32'h1F, 32'h0000007F, 32'h0, 0);
        q(0, 2, 0, 32'h1C, 32'h0, 32'h7FA50F0F, 0);
        q(0, 0, 1, 32'h1E, 32'h0, 32'h000000A5, 0);
        wait_idle();
        chk("mem_word_0x14", mem[5], 32'h12340000);

        saved = word_of(16);
        q(1, 0, 0, 32'h11, 32'h00000077, 32'h0, 0);
        n = 0;
        while (reqq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2 reset = 1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp_rdata", resp_rdata, 32'd0);
        chk("mid_rst_resp_error", 32'(resp_error), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_write_enable), 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_mem_wdata", mem_write_data, 32'd0);
        pend.delete();
        wcount = 0;
        for (int i = 0; i < 4; i++) bytes[16 + i] = saved[8*i +: 8];
        repeat (3) @(negedge clk);
        #2;
        chk("writes_during_reset", 32'(wcount), 32'd0);
        chk("mem_0x10_after_reset", mem[4], saved);
        reset = 0;

        q(0, 2, 0, 32'h10, 32'h0, 32'hDE5ABEEF, 0);
        wait_idle();
        for (int w = 0; w < 9; w++) chk("final_mem", mem[w], word_of(4 * w));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator between the pipeline's MEM stage and the word-addressed data memory. Accepts one load/store request at a time over a valid/ready handshake and issues the word-level reads and writes the memory port understands. Provides byte/halfword/word access with sign or zero extension, performs read-modify-write for sub-word stores, and reports misaligned, out-of-range or illegal-size requests as errors without touching memory.

## Interface

Parameters:
- MEM_WORDS, 4096: number of 32-bit words in the attached data memory; word index `addr[31:2] >= MEM_WORDS` is out of range.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid; 1 = request rejected.
- mem_addr  out  32  word-aligned byte address `{addr[31:2],2'b00}` to data memory.
- mem_write_data  out  32  word written to data memory.
- mem_write_enable  out  1  memory write strobe; memory writes on rising clk.
- mem_read_data  in  32  combinational read of word at mem_addr.

## Operation

- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. Handshake occurs on rising edge with req_valid&&req_ready; addr, size, write, unsigned, wdata registered.
- Error check at accept: size 11, half with addr[0]=1, word with addr[1:0]!=0, or out-of-range → RESP with resp_error=1, resp_rdata=0; no memory access.
- Load: IDLE→READ→RESP. In READ, mem_addr valid; on the edge, lane extracted from mem_read_data and extended into resp_rdata.
- Store word: IDLE→WRITE→RESP. In WRITE, mem_write_enable=1, mem_write_data=req_wdata.
- Store byte/half: IDLE→READ→WRITE→RESP. READ captures mem_read_data; merged word (new lane replacing old lane, other bytes untouched) registered; WRITE drives it with mem_write_enable=1.
- Byte lanes little-endian: offset 0 → [7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24]; half offset 0 → [15:0], 2 → [31:16].
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_error hold until next RESP.
- mem_write_enable is high only in WRITE; mem_addr holds last value otherwise.

## Timing

- Accept edge = E0. resp_valid high in cycle after: E0 for error (latency 1), E1 for load and word store (latency 2), E2 for sub-word store (latency 3).
- Memory write lands on the edge ending the WRITE cycle; a load issued immediately after returns the new data.
- Next request accepted no earlier than the IDLE cycle following RESP; max throughput one request per 2/3/4 cycles.
- req_* inputs ignored outside IDLE.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_error 0, mem_write_enable 0, mem_addr 0, mem_write_data 0.
- Reset mid-operation: state forced to IDLE asynchronously; mem_write_enable drops immediately, so no write occurs at any edge while reset is high; pending response discarded.

## Test plan

- Store word 0xDEADBEEF to 0x10, then load word 0x10 → resp_rdata=0xDEADBEEF, resp_error=0; resp_valid 2 cycles after each accept.
- After above, store byte 0x5A at 0x12 → memory word 0x10 = 0xDE5ABEEF; resp_valid 3 cycles after accept; mem_write_enable high exactly one cycle.
- Load byte signed at 0x13 → 0xFFFFFFDE; unsigned → 0x000000DE; load half signed at 0x10 → 0xFFFFBEEF; unsigned → 0x0000BEEF.
- Misaligned half store at 0x11, word load at 0x12, size 11, and addr 0x4000 (MEM_WORDS=4096) → resp_error=1, resp_rdata=0, latency 1, mem_write_enable never asserted, memory unchanged.
- req_valid held high continuously with alternating load/store → req_ready low except IDLE, each request accepted exactly once, responses in order.
- Assert reset during READ of a sub-word store → state IDLE, all outputs at reset values, target memory word unchanged, no resp_valid.
